// File: rtl/axis_pkt_stream_out.sv
// axis_pkt_stream_out: packs PACK FIFO samples per beat, queues beats in an
// OUT_DEPTH-entry output queue and frames them into PKT_BEATS-beat packets.
// On loss of enable/aligned, queued beats are still delivered and an open
// packet is padded with PAD_VALUE up to its final beat.
module axis_pkt_stream_out #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       PACK      = 2,
    parameter int unsigned       PKT_BEATS = 64,
    parameter int unsigned       OUT_DEPTH = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enable,
    input  logic                     aligned,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    input  logic                     fifo_rd_valid,
    input  logic                     fifo_rd_empty,
    output logic                     fifo_rd_en,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*PACK-1:0]   m_data,
    output logic                     m_last,
    output logic [15:0]              pkt_count,
    output logic                     pad_active,
    output logic                     busy
);

    localparam int unsigned PCW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned BCW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int unsigned QAW = $clog2(OUT_DEPTH);
    localparam int unsigned QCW = QAW + 1;
    localparam int unsigned QSW = QCW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PAD,
        S_FLUSHQ
    } state_t;

    state_t                         r_state;
    logic [PACK-1:0][DATA_W-1:0]    r_pack;
    logic [PCW-1:0]                 r_pack_cnt;
    logic [BCW-1:0]                 r_beat_cnt;
    logic                           r_rd_inflight;
    logic [PACK-1:0][DATA_W-1:0]    r_q_data [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]           r_q_last;
    logic [QAW-1:0]                 r_wr_ptr;
    logic [QAW-1:0]                 r_rd_ptr;
    logic [QCW-1:0]                 r_q_count;
    logic [15:0]                    r_pkt_count;

    logic                           w_go;
    logic                           w_reserved;
    logic                           w_rd_en;
    logic                           w_pad_we;
    logic                           w_smp_we;
    logic [DATA_W-1:0]              w_smp;
    logic                           w_beat_end;
    logic                           w_enq;
    logic                           w_enq_last;
    logic                           w_deq;
    logic                           w_valid;
    logic [PACK-1:0][DATA_W-1:0]    w_beat;

    assign w_go    = enable && aligned;
    assign w_valid = (r_q_count != '0);
    assign w_deq   = w_valid && m_ready;

    // Read request with queue-slot reservation, sample source select and beat assembly
    always_comb begin
        w_reserved = (r_pack_cnt != '0) || r_rd_inflight;
        w_rd_en    = (r_state == S_RUN) && w_go && !fifo_rd_empty &&
                     (({1'b0, r_q_count} + QSW'(w_reserved)) < QSW'(OUT_DEPTH));
        w_pad_we   = (r_state == S_PAD) && (r_q_count < QCW'(OUT_DEPTH));
        w_smp_we   = (r_rd_inflight && fifo_rd_valid) || w_pad_we;
        w_smp      = w_pad_we ? PAD_VALUE : fifo_rd_data;
        w_beat_end = (r_pack_cnt == PCW'(PACK - 1));
        w_enq      = w_smp_we && w_beat_end;
        w_enq_last = (r_beat_cnt == BCW'(PKT_BEATS - 1));
        w_beat             = r_pack;
        w_beat[r_pack_cnt] = w_smp;
    end

    // Control FSM; DRAIN waits for an outstanding read before deciding to pad
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_go) r_state <= S_RUN;
                S_RUN:    if (!w_go) r_state <= S_DRAIN;
                S_DRAIN:  if (!r_rd_inflight)
                              r_state <= ((r_pack_cnt == '0) && (r_beat_cnt == '0)) ? S_FLUSHQ : S_PAD;
                S_PAD:    if (w_enq && w_enq_last) r_state <= S_FLUSHQ;
                S_FLUSHQ: if (r_q_count == '0) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Pack register, beat framing counter, in-flight read tracking and packet counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pack        <= '0;
            r_pack_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_rd_inflight <= 1'b0;
            r_pkt_count   <= '0;
        end else begin
            r_rd_inflight <= w_rd_en || (r_rd_inflight && !fifo_rd_valid);
            if (w_smp_we) begin
                r_pack[r_pack_cnt] <= w_smp;
                r_pack_cnt         <= w_beat_end ? '0 : r_pack_cnt + PCW'(1);
            end
            if (w_enq)
                r_beat_cnt <= w_enq_last ? '0 : r_beat_cnt + BCW'(1);
            if (w_deq && r_q_last[r_rd_ptr])
                r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    // Output queue: circular buffer, simultaneous push and pop keep the count
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++)
                r_q_data[i] <= '0;
            r_q_last  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_enq) begin
                r_q_data[r_wr_ptr] <= w_beat;
                r_q_last[r_wr_ptr] <= w_enq_last;
                r_wr_ptr           <= r_wr_ptr + QAW'(1);
            end
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + QAW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_q_count <= r_q_count + QCW'(1);
                2'b01:   r_q_count <= r_q_count - QCW'(1);
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(w_enq && !w_deq && (r_q_count == QCW'(OUT_DEPTH))));

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_valid;
    assign m_data     = r_q_data[r_rd_ptr];
    assign m_last     = r_q_last[r_rd_ptr];
    assign pkt_count  = r_pkt_count;
    assign pad_active = (r_state == S_PAD);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/axis_pkt_stream_out.md
Name: axis_pkt_stream_out

Overview:
- Parametrised successor of the single-register FIFO-to-stream stage.
- Reads DATA_W-bit samples from the sample FIFO (sys_clk domain) and packs PACK samples into each output beat.
- Buffers beats in an OUT_DEPTH-entry output queue so full throughput survives backpressure.
- Frames the stream into fixed packets of PKT_BEATS beats with m_last. On disable or loss of alignment, already-queued beats are delivered, never flushed, and an open packet is padded to completion.

Parameters:
DATA_W, 16, sample width in bits
PACK, 2, samples per output beat (1..8)
PKT_BEATS, 64, beats per packet (>=1); m_last on final beat
OUT_DEPTH, 4, output queue entries (>=2, power of two)
PAD_VALUE, 0, DATA_W-bit sample value used for padding

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous reset, active-high
enable  in  1  streaming enable
aligned  in  1  front-end alignment status
fifo_rd_data  in  DATA_W  FIFO read data
fifo_rd_valid  in  1  FIFO data valid, one cycle after an accepted fifo_rd_en
fifo_rd_empty  in  1  FIFO empty
fifo_rd_en  out  1  FIFO read request
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  DATA_W*PACK  packed beat; sample 0 in LSBs
m_last  out  1  final beat of packet
pkt_count  out  16  packets completed (m_last handshakes), wraps at 65535->0
pad_active  out  1  high while the block is generating pad samples
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (sys_clk). Reset sys_rst is asynchronous and active-high.
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_count=0, pad_active=0, busy=0.
  - Queue is empty; pack_cnt=0, beat_cnt=0, rd_inflight=0; state=IDLE.
  - Reset asserted mid-operation discards all queued, partial and in-flight data. A fifo_rd_valid pulse arriving after reset release is ignored unless rd_inflight=1.
- Run condition: go = enable && aligned.
- States:
  - IDLE: go -> RUN.
  - RUN: !go -> DRAIN.
  - DRAIN: absorb an in-flight read if one is outstanding. Then:
    - if pack_cnt==0 and beat_cnt==0 -> FLUSHQ;
    - else -> PAD.
  - PAD: push PAD_VALUE into the pack register, one sample per cycle, while queue space exists. When the beat carrying m_last is enqueued -> FLUSHQ.
  - FLUSHQ: wait until the queue is empty -> IDLE.
  - go re-asserted in DRAIN, PAD or FLUSHQ has no effect until IDLE is reached. No read is issued before then.
- Read request (combinational):
  - fifo_rd_en = (state==RUN) && go && !fifo_rd_empty && (q_count + reserved < OUT_DEPTH).
  - reserved = 1 if pack_cnt>0 or rd_inflight, else 0.
  - rd_inflight is set the cycle after fifo_rd_en=1 and clears when fifo_rd_valid is seen.
  - Sustains 1 sample/cycle with m_ready=1.
- Packing:
  - Each fifo_rd_valid, or each pad sample, writes slot pack_cnt and increments pack_cnt.
  - At pack_cnt==PACK-1 the beat is enqueued the same cycle; pack_cnt->0.
  - m_last for the enqueued beat = (beat_cnt==PKT_BEATS-1). beat_cnt wraps to 0 after that beat, else increments.
  - Latency: last sample of a beat (fifo_rd_valid) -> m_valid, one cycle when the queue is empty.
- Output handshake:
  - The beat transfers when m_valid && m_ready.
  - While m_valid=1 && m_ready=0, m_data and m_last are held stable.
  - Enqueue and dequeue in the same cycle are legal; q_count is unchanged.
  - The queue never overflows: the reservation rule guarantees space. Overflow is an assertion failure.
- pkt_count increments on each handshake with m_last=1.
- pad_active = (state==PAD).
- busy = (state!=IDLE).
- Losing aligned behaves exactly like losing enable. Queued beats are still delivered, unlike the previous generation.

Test Plan:
- Defaults are DATA_W=16, PACK=2, PKT_BEATS=4, OUT_DEPTH=4.
1. Continuous stream: FIFO supplies 0x0001..0x0010, m_ready=1 -> beats 0x00020001, 0x00040003, ...; m_last on 0x00080007 and 0x0010000F; pkt_count=2; no gaps after the first beat.
2. Backpressure: m_ready=0 for 10 cycles mid-packet.
   - m_valid held; m_data/m_last stable.
   - fifo_rd_en drops once q_count+reserved=4.
   - After release: no sample lost or duplicated (scoreboard compare).
3. Disable after 3 samples (0x0001..0x0003):
   - beats 0x00020001, then 0x00000003, then 0x00000000 twice;
   - m_last on the 4th beat; pad_active high during padding;
   - pkt_count=1; busy falls after the last handshake.
4. Disable exactly after the 8th sample of a packet, queue full, m_ready=0 -> no pad beats. The 4 queued beats are delivered once m_ready=1, then IDLE.
5. FIFO empty gaps: fifo_rd_empty toggles every other cycle -> fifo_rd_en never asserted while empty; beat contents remain in order.
6. sys_rst pulsed with m_valid=1 mid-packet -> m_valid=0, pkt_count=0, busy=0 immediately. After release with go=1, the first beat is a fresh packet (beat_cnt restarts, m_last on the 4th beat).
